// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants and types for the multicycle MIPS datapath:
//                opcodes, R-type funct codes, ALU B-operand select encodings,
//                ALUOp classes and the internal ALU operation enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type funct codes, IR[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALUOp classes from the control FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  // Internal ALU operation after ALU-control decode
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mips_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : mips_regfile
//  Description : 32 x 32-bit register file. Two combinational read ports, one
//                synchronous write port, asynchronous active-low clear.
//                Register 0 reads as zero and ignores writes.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                raddr1_i/rdata1_o     - read port 1
//                raddr2_i/rdata2_o     - read port 2
//                we_i/waddr_i/wdata_i  - write port
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write returns old data.
  assign rdata1_o = (raddr1_i == 5'd0) ? 32'h0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'h0 : regs_q[raddr2_i];

endmodule : mips_regfile
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_datapath
//  Description : Multicycle MIPS datapath (PC, IR, MDR, A, B, ALUOut, register
//                file, ALU with inline ALU-control decode). Driven by control
//                strobes from an external control FSM.
//  Ports       : clk, reset (async active-low)
//                IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
//                ALUSrcA, RegWrite, RegDst, PCSel, ALUSrcB[1:0], ALUOp[1:0]
//                                      - control strobes in
//                Op[5:0], Zero         - status to the control FSM
//                mem_addr, mem_wdata, mem_rd, mem_wr, mem_rdata
//                                      - combinational memory interface
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_datapath
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        IRWrite,
  input  logic        PCSource,
  input  logic        ALUSrcA,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        PCSel,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ALUOp,
  output logic [5:0]  Op,
  output logic        Zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] aluout_q, aluout_d;

  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic [4:0]  rf_waddr;
  logic [31:0] imm_sext, alu_a, alu_b, alu_result;
  alu_op_e     alu_ctrl;

  mips_regfile u_regfile (
    .clk      (clk),
    .rst_n    (reset),
    .raddr1_i (ir_q[25:21]),
    .raddr2_i (ir_q[20:16]),
    .rdata1_o (rf_rdata1),
    .rdata2_o (rf_rdata2),
    .we_i     (RegWrite),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata)
  );

  assign rf_waddr = RegDst   ? ir_q[15:11] : ir_q[20:16];
  assign rf_wdata = MemtoReg ? mdr_q       : aluout_q;

  // Operand selection
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign alu_a    = ALUSrcA ? a_q : pc_q;

  always_comb begin
    alu_b = b_q;
    case (ALUSrcB)
      SRCB_REG:     alu_b = b_q;
      SRCB_FOUR:    alu_b = 32'd4;
      SRCB_IMM:     alu_b = imm_sext;
      SRCB_IMM_SH2: alu_b = {imm_sext[29:0], 2'b00};
      default:      alu_b = b_q;
    endcase
  end

  // ALU control: only the funct class looks at IR; unknown functs add.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (ir_q[5:0])
          FUNCT_ADD: alu_ctrl = ALU_ADD;
          FUNCT_SUB: alu_ctrl = ALU_SUB;
          FUNCT_AND: alu_ctrl = ALU_AND;
          FUNCT_OR:  alu_ctrl = ALU_OR;
          FUNCT_SLT: alu_ctrl = ALU_SLT;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      default:   alu_ctrl = ALU_ADD;
    endcase
  end

  // ALU; arithmetic wraps modulo 2^32
  always_comb begin
    alu_result = alu_a + alu_b;
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = alu_a + alu_b;
    endcase
  end

  // Next-state: every register samples pre-edge values, so PCSel and IRWrite
  // on the same edge are independent.
  always_comb begin
    pc_d     = pc_q;
    if (PCSel) begin
      pc_d = PCSource ? aluout_q : alu_result;
    end
    ir_d     = IRWrite ? mem_rdata : ir_q;
    mdr_d    = mem_rdata;
    a_d      = rf_rdata1;
    b_d      = rf_rdata2;
    aluout_d = alu_result;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  assign Op        = ir_q[31:26];
  assign Zero      = (alu_result == 32'h0);
  assign mem_addr  = IorD ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign mem_rd    = MemRead;
  assign mem_wr    = MemWrite;

endmodule : multicycle_datapath
`default_nettype wire
